// File: rtl/evr_pkg.sv
// Shared constants and FSM state type for the EVR segmented-data-buffer receiver.
package evr_pkg;

  localparam int unsigned EVR_DATA_BYTES = 16;
  localparam int unsigned EVR_CNT_W      = 16;
  localparam logic [7:0]  EVR_K_START    = 8'h5C;  // K28.2
  localparam logic [7:0]  EVR_K_STOP     = 8'h3C;  // K28.1
  localparam logic [7:0]  EVR_K_COMMA    = 8'hBC;  // K28.5

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    STOP,
    CSUM_H,
    CSUM_L
  } segbuf_state_t;

  function automatic logic [15:0] evr_csum_expect(input logic [15:0] sum);
    return 16'hFFFF - sum;
  endfunction

endpackage

// File: rtl/evr_slot_sync.sv
// Comma detection and DBUS/DATA slot phase tracking for the 16-bit rx word stream.
module evr_slot_sync
  import evr_pkg::*;
#(
  parameter logic [7:0] K_COMMA = EVR_K_COMMA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_ready_i,
  input  logic [7:0] ev_byte_i,
  input  logic       ev_isk_i,
  output logic       synced_o,
  output logic       dbus_slot_o,
  output logic       realign_o
);

  logic synced_q, synced_d;
  logic expect_dbus_q, expect_dbus_d;
  logic comma;

  // The comma word itself is usable, so synced_o covers the very first comma.
  always_comb begin
    comma         = ev_isk_i && (ev_byte_i == K_COMMA);
    synced_d      = rx_ready_i && (synced_q || comma);
    dbus_slot_o   = comma || expect_dbus_q;
    realign_o     = rx_ready_i && synced_q && comma && !expect_dbus_q;
    expect_dbus_d = synced_d ? !dbus_slot_o : 1'b0;
    synced_o      = synced_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      synced_q      <= 1'b0;
      expect_dbus_q <= 1'b0;
    end else begin
      synced_q      <= synced_d;
      expect_dbus_q <= expect_dbus_d;
    end
  end

endmodule

// File: rtl/segbuf_frame_rx.sv
// EVR rx parser: splits distributed-bus bytes from segmented-buffer bytes and emits checked segments.
module segbuf_frame_rx
  import evr_pkg::*;
#(
  parameter int unsigned DATA_BYTES = EVR_DATA_BYTES,
  parameter logic [7:0]  K_START    = EVR_K_START,
  parameter logic [7:0]  K_STOP     = EVR_K_STOP,
  parameter logic [7:0]  K_COMMA    = EVR_K_COMMA,
  parameter int unsigned CNT_W      = EVR_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_ready,
  input  logic [15:0]             rx_data,
  input  logic [1:0]              rx_charisk,
  input  logic                    rx_err,
  output logic [7:0]              dbus,
  output logic                    dbus_valid,
  output logic                    seg_valid,
  output logic [7:0]              seg_addr,
  output logic [8*DATA_BYTES-1:0] seg_data,
  output logic [CNT_W-1:0]        frames_ok,
  output logic [CNT_W-1:0]        frames_err,
  output logic                    busy
);

  localparam int unsigned        IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BYTES - 1);

  segbuf_state_t state_q, state_d;

  logic [7:0]                    addr_q, addr_d;
  logic [15:0]                   sum_q, sum_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    csh_q, csh_d;
  logic [DATA_BYTES-1:0][7:0]    stage_q, stage_d;
  logic [7:0]                    dbus_q, dbus_d;
  logic                          dbus_valid_q, dbus_valid_d;
  logic                          seg_valid_q, seg_valid_d;
  logic [7:0]                    seg_addr_q, seg_addr_d;
  logic [8*DATA_BYTES-1:0]       seg_data_q, seg_data_d;
  logic [CNT_W-1:0]              frames_ok_q, frames_ok_d;
  logic [CNT_W-1:0]              frames_err_q, frames_err_d;

  logic       synced, dbus_slot, realign;
  logic       ok_inc, err_inc, in_frame;
  logic [7:0] b;
  logic       k;

  evr_slot_sync #(
    .K_COMMA (K_COMMA)
  ) u_slot_sync (
    .clk         (clk),
    .reset       (reset),
    .rx_ready_i  (rx_ready),
    .ev_byte_i   (rx_data[15:8]),
    .ev_isk_i    (rx_charisk[1]),
    .synced_o    (synced),
    .dbus_slot_o (dbus_slot),
    .realign_o   (realign)
  );

  always_comb begin
    b            = rx_data[7:0];
    k            = rx_charisk[0];
    in_frame     = (state_q != IDLE);
    state_d      = state_q;
    addr_d       = addr_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    csh_d        = csh_q;
    stage_d      = stage_q;
    dbus_d       = dbus_q;
    dbus_valid_d = 1'b0;
    seg_valid_d  = 1'b0;
    seg_addr_d   = seg_addr_q;
    seg_data_d   = seg_data_q;
    ok_inc       = 1'b0;
    err_inc      = 1'b0;

    if (synced && dbus_slot && !k) begin
      dbus_d       = b;
      dbus_valid_d = 1'b1;
    end

    // Link loss, line errors and phase slips all abort before any slot decoding.
    if (!synced) begin
      err_inc = in_frame;
      state_d = IDLE;
    end else if (in_frame && (rx_err || realign)) begin
      err_inc = 1'b1;
      state_d = IDLE;
    end else if (!dbus_slot) begin
      case (state_q)
        IDLE: begin
          if (k && b == K_START) state_d = ADDR;
        end
        ADDR: begin
          if (!k) begin
            addr_d  = b;
            sum_d   = {8'h00, b};
            idx_d   = '0;
            state_d = DATA;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
        DATA: begin
          if (!k) begin
            stage_d[idx_q] = b;
            sum_d          = sum_q + {8'h00, b};
            idx_d          = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = STOP;
          end else begin
            err_inc = 1'b1;
            state_d = (b == K_START) ? ADDR : IDLE;
          end
        end
        STOP: begin
          if (k && b == K_STOP) begin
            state_d = CSUM_H;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
        CSUM_H: begin
          if (!k) begin
            csh_d   = b;
            state_d = CSUM_L;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
        CSUM_L: begin
          state_d = IDLE;
          if (!k && ({csh_q, b} == evr_csum_expect(sum_q))) begin
            ok_inc      = 1'b1;
            seg_valid_d = 1'b1;
            seg_addr_d  = addr_q;
            seg_data_d  = stage_q;
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    frames_ok_d  = (ok_inc && frames_ok_q != '1) ? frames_ok_q + CNT_W'(1) : frames_ok_q;
    frames_err_d = (err_inc && frames_err_q != '1) ? frames_err_q + CNT_W'(1) : frames_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      csh_q        <= '0;
      stage_q      <= '0;
      dbus_q       <= '0;
      dbus_valid_q <= 1'b0;
      seg_valid_q  <= 1'b0;
      seg_addr_q   <= '0;
      seg_data_q   <= '0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      csh_q        <= csh_d;
      stage_q      <= stage_d;
      dbus_q       <= dbus_d;
      dbus_valid_q <= dbus_valid_d;
      seg_valid_q  <= seg_valid_d;
      seg_addr_q   <= seg_addr_d;
      seg_data_q   <= seg_data_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
    end
  end

  assign dbus       = dbus_q;
  assign dbus_valid = dbus_valid_q;
  assign seg_valid  = seg_valid_q;
  assign seg_addr   = seg_addr_q;
  assign seg_data   = seg_data_q;
  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;
  assign busy       = in_frame;

endmodule

// File: tb/tb_segbuf_frame_rx.sv
// Directed bench for segbuf_frame_rx with queue-based scoreboard for segments and dbus bytes.
module tb_segbuf_frame_rx;

  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_ready;
  logic [15:0]     rx_data;
  logic [1:0]      rx_charisk;
  logic            rx_err;
  logic [7:0]      dbus;
  logic            dbus_valid;
  logic            seg_valid;
  logic [7:0]      seg_addr;
  logic [8*NB-1:0] seg_data;
  logic [15:0]     frames_ok;
  logic [15:0]     frames_err;
  logic            busy;

  segbuf_frame_rx #(
    .DATA_BYTES (NB),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_charisk (rx_charisk),
    .rx_err     (rx_err),
    .dbus       (dbus),
    .dbus_valid (dbus_valid),
    .seg_valid  (seg_valid),
    .seg_addr   (seg_addr),
    .seg_data   (seg_data),
    .frames_ok  (frames_ok),
    .frames_err (frames_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_ok = 0;
  int exp_err = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0]      addr;
    logic [8*NB-1:0] data;
    int              due;
  } seg_t;

  typedef struct {
    logic [7:0] b;
    int         due;
  } db_t;

  seg_t segq[$];
  db_t  dbq[$];
  seg_t seg_e;
  db_t  db_e;

  task automatic chk(input string tag, input logic [8*NB-1:0] obs, input logic [8*NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (seg_valid === 1'b1) begin
      if (segq.size() == 0) begin
        chk("seg_unexpected", 1, 0);
      end else begin
        seg_e = segq.pop_front();
        chk("seg_addr", seg_addr, seg_e.addr);
        chk("seg_data", seg_data, seg_e.data);
        chk("seg_latency", cyc, seg_e.due);
      end
    end
    if (dbus_valid === 1'b1) begin
      if (dbq.size() == 0) begin
        chk("dbus_unexpected", 1, 0);
      end else begin
        db_e = dbq.pop_front();
        chk("dbus_byte", dbus, db_e.b);
        chk("dbus_latency", cyc, db_e.due);
      end
    end
  end

  task automatic word(input logic [7:0] ev, input logic evk, input logic [7:0] d,
                      input logic dk, input logic err);
    rx_data    = {ev, d};
    rx_charisk = {evk, dk};
    rx_err     = err;
    @(negedge clk);
  endtask

  task automatic dbw(input logic [7:0] d, input logic dk);
    if (!dk && rx_ready) dbq.push_back('{d, cyc + 1});
    word(8'h00, 1'b0, d, dk, 1'b0);
  endtask

  task automatic pair(input logic [7:0] b, input logic k, input logic err = 1'b0);
    dbw(8'h00, 1'b1);
    word(8'h00, 1'b0, b, k, err);
  endtask

  task automatic comma();
    word(8'hBC, 1'b1, 8'hBC, 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] csum(input logic [7:0] a, input logic [8*NB-1:0] d);
    logic [15:0] s;
    s = {8'h00, a};
    for (int i = 0; i < NB; i++) s = s + {8'h00, d[i*8 +: 8]};
    return 16'hFFFF - s;
  endfunction

  task automatic frame(input logic [7:0] a, input logic [8*NB-1:0] d, input logic [15:0] cs);
    logic good;
    good = (cs == csum(a, d));
    pair(8'h5C, 1'b1);
    chk("busy_in_frame", busy, 1);
    pair(a, 1'b0);
    for (int i = 0; i < NB; i++) pair(d[i*8 +: 8], 1'b0);
    pair(8'h3C, 1'b1);
    pair(cs[15:8], 1'b0);
    dbw(8'h00, 1'b1);
    if (good) segq.push_back('{a, d, cyc + 1});
    word(8'h00, 1'b0, cs[7:0], 1'b0, 1'b0);
    if (good) exp_ok++;
    else      exp_err++;
  endtask

  task automatic counters(input string tag);
    chk({tag, "_ok"}, frames_ok, exp_ok);
    chk({tag, "_err"}, frames_err, exp_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_seg_pending"}, segq.size(), 0);
  endtask

  logic [8*NB-1:0] d1, d3;

  initial begin
    d1 = '0;
    d1[8 +: 8]   = 8'h8B;
    d1[16 +: 8]  = 8'hFC;
    d1[24 +: 8]  = 8'h7B;
    d1[56 +: 8]  = 8'h07;
    d1[120 +: 8] = 8'h07;
    for (int i = 0; i < NB; i++) d3[i*8 +: 8] = 8'(8'h30 + i * 7);

    reset = 1'b1; rx_ready = 1'b1; rx_data = '0; rx_charisk = '0; rx_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dbus", dbus, 0);
    chk("rst_dbus_valid", dbus_valid, 0);
    chk("rst_seg_valid", seg_valid, 0);
    chk("rst_seg_addr", seg_addr, 0);
    chk("rst_seg_data", seg_data, 0);
    chk("rst_frames_ok", frames_ok, 0);
    chk("rst_frames_err", frames_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    comma();
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reference frame with checksum FCF0
    frame(8'hFF, d1, 16'hFCF0);
    pair(8'h00, 1'b1);
    counters("t1");

    // Corrupt checksum
    frame(8'hFF, d1, 16'hFCF1);
    pair(8'h00, 1'b1);
    counters("t2");

    // Restart: second K28.2 after five data bytes
    pair(8'h5C, 1'b1);
    pair(8'h55, 1'b0);
    for (int i = 0; i < 5; i++) pair(8'(8'hA0 + i), 1'b0);
    exp_err++;
    frame(8'h04, d3, csum(8'h04, d3));
    pair(8'h00, 1'b1);
    counters("t3");
    chk("t3_seg_addr_hold", seg_addr, 8'h04);

    // Distributed bus bytes
    dbw(8'h11, 1'b0);
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    dbw(8'h22, 1'b0);
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_dbus_last", dbus, 8'h22);
    chk("t4_dbq_pending", dbq.size(), 0);

    // Reset mid-DATA
    pair(8'h5C, 1'b1);
    pair(8'h33, 1'b0);
    for (int i = 0; i < 3; i++) pair(8'h44, 1'b0);
    reset = 1'b1;
    repeat (3) word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    counters("t5_rst");
    chk("t5_seg_addr_rst", seg_addr, 0);
    comma();
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    frame(8'h07, d3, csum(8'h07, d3));
    pair(8'h00, 1'b1);
    counters("t5");

    // Comma lands in a DATA slot mid-frame
    pair(8'h5C, 1'b1);
    pair(8'h09, 1'b0);
    for (int i = 0; i < 3; i++) pair(8'h66, 1'b0);
    dbw(8'h00, 1'b1);
    comma();
    exp_err++;
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    counters("t6_realign");
    frame(8'h0A, d1, csum(8'h0A, d1));
    pair(8'h00, 1'b1);
    counters("t6_after_realign");

    // Line error during DATA
    pair(8'h5C, 1'b1);
    pair(8'h0B, 1'b0);
    pair(8'h01, 1'b0);
    pair(8'h02, 1'b0);
    pair(8'h12, 1'b0, 1'b1);
    exp_err++;
    pair(8'h00, 1'b1);
    counters("t6_rxerr");

    // Link drop mid-frame, no dbus while down
    pair(8'h5C, 1'b1);
    pair(8'h0C, 1'b0);
    rx_ready = 1'b0;
    exp_err++;
    word(8'h00, 1'b0, 8'h77, 1'b0, 1'b0);
    word(8'h00, 1'b0, 8'h78, 1'b0, 1'b0);
    rx_ready = 1'b1;
    comma();
    word(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    counters("t7_link");
    frame(8'h0D, d3, csum(8'h0D, d3));
    pair(8'h00, 1'b1);
    counters("t7_final");
    chk("dbq_final", dbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
